rs_syndrome: RTL and testbench
==============================

# rs_syndrome

Reed-Solomon syndrome calculator over GF(2^8). It sits directly downstream of the RS encoder / channel and is the first stage of the RS decoder. It consumes one received codeword symbol per valid beat and evaluates the received polynomial at NSYM consecutive roots by Horner's rule. After the last symbol it presents all syndromes plus a nonzero flag to the key-equation stage.

## Interface
- NSYM, 4, number of parity symbols, which is also the number of syndromes S_0..S_{NSYM-1}
- FCR, 0, first consecutive root; syndrome j is evaluated at alpha^(FCR+j)
- CW_LEN, 255, expected codeword length in symbols; used only when the length check is compiled in
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_data is a codeword symbol this cycle
- in_last  in  1  qualifies the final symbol of a codeword; ignored unless in_valid
- in_data  in  8  received symbol, highest-degree coefficient first, parity last
- syn_valid  out  1  one-cycle pulse: syndromes updated
- syn_out  out  NSYM*8  S_j in bits [8j+7:8j]
- syn_err  out  1  OR of all S_j nonzero; qualified by syn_valid, held afterwards
- len_err  out  1  length mismatch; present only with RSSYN_LEN_CHECK_EN

## Operation
- Field: GF(2^8), primitive polynomial 0x11D, alpha = 0x02.
- State machine has two states, IDLE and ACCUM.
  - IDLE: the next valid beat is the first symbol. Load acc_j <= in_data for all j and go to ACCUM.
  - ACCUM: on a valid beat, acc_j <= acc_j * alpha^(FCR+j) XOR in_data.
  - On any valid beat with in_last, the next value goes to syn_out and the state returns to IDLE.
  - A valid beat with in_last while in IDLE is a one-symbol codeword: syn_out = in_data in every lane, and the state stays IDLE.
- in_valid low: accumulators, state and outputs hold. Gaps are allowed anywhere inside a codeword.
- Multipliers are constant GF multiplications, purely XOR networks. There are no table lookups and no general multiplier.
- No backpressure. Back-to-back codewords are accepted with zero idle cycles.
- syn_out and syn_err hold their values until the next in_last beat.

## Timing
- Reset values: state=IDLE, acc=0, syn_out=0, syn_valid=0, syn_err=0, len_err=0.
- Latency: syn_valid is high in the cycle after the clock edge that sampled in_valid && in_last. syn_out and syn_err are valid in that same cycle.
- Throughput: one symbol per clock. syn_valid can pulse on consecutive cycles when consecutive one-symbol codewords arrive.
- Reset mid-codeword discards the partial codeword; no syn_valid is produced for it. The first valid beat after reset is treated as a first symbol.
- A new codeword's first symbol arriving in the same cycle that syn_valid is high is legal.

## Configuration
- RSSYN_LEN_CHECK_EN defined:
  - An 8-bit symbol counter counts valid beats in the current codeword.
  - On the in_last beat, len_err is registered as (count != CW_LEN) and updates together with syn_valid.
  - The counter saturates at 255 and clears to 0 in IDLE.
  - Syndrome computation is unaffected.
- RSSYN_LEN_CHECK_EN undefined: no counter and no len_err port.

## Structure
- Package gf256_pkg:
  - PRIM_POLY = 9'h11D
  - function gf_mul_alpha_pow(value, power), an elaborated constant multiply
  - the symbol typedef logic [7:0]
- The package is shared with the encoder and the later decoder stages.
- Sub-module rs_syn_cell: one syndrome lane with parameter ROOT_POW, holding the accumulator register and the Horner update. Instantiate NSYM times by generate.
- The top holds the state machine, syn_valid, syn_err reduction and the optional length counter.

## Test plan
All cases use NSYM=4, FCR=0 unless noted.
- All-zero codeword of 255 beats with in_last on the last beat -> syn_valid one cycle later, syn_out=0, syn_err=0.
- Two beats, 0x01 then 0x00 (last) -> S0=01, S1=02, S2=04, S3=08, syn_err=1.
- One-symbol codeword 0x12 with in_valid and in_last together -> all S_j=12.
  - A second codeword 0x34 follows on the next cycle -> syn_valid pulses two cycles in a row, the second with S_j=34.
- Valid codeword from the encoder golden model with random in_valid gaps -> all S_j=0.
  - The same codeword with byte 0xA5 XORed into the symbol of degree 1 (second-to-last) -> S_j = 0xA5 * alpha^j, i.e. A5, 57, AE, 41.
- Assert rst for one cycle after 3 beats, then send the two-beat codeword from scenario 2 -> no syn_valid for the aborted codeword, then S = 01, 02, 04, 08.
- With RSSYN_LEN_CHECK_EN and CW_LEN=7:
  - 7-beat codeword -> len_err=0.
  - 6-beat codeword -> len_err=1 in the syn_valid cycle.

Source files
------------

// File: rtl/gf256_pkg.sv
// GF(2^8) helpers shared by the RS encoder, syndrome and decoder stages.
// Field polynomial 0x11D, alpha = 0x02; constant multiplies only.
package gf256_pkg;

    localparam logic [8:0] PRIM_POLY = 9'h11D;

    typedef logic [7:0] symbol_t;

    // Multiply by alpha: shift left, fold x^8 back through the polynomial.
    function automatic symbol_t gf_mul_alpha(input symbol_t v);
        symbol_t r;
        r = {v[6:0], 1'b0} ^ (v[7] ? PRIM_POLY[7:0] : 8'h00);
        return r;
    endfunction

    // Multiply by alpha^power. With a constant power this elaborates to a
    // pure XOR network; alpha has order 255 so the exponent wraps.
    function automatic symbol_t gf_mul_alpha_pow(input symbol_t value,
                                                 input int power);
        symbol_t r;
        r = value;
        for (int i = 0; i < (power % 255); i++) begin
            r = gf_mul_alpha(r);
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_syn_cell.sv
// One syndrome lane: Horner accumulator evaluated at alpha^ROOT_POW.
// Ports: clk, rst, en (valid beat), first (load instead of accumulate),
//        in_data (symbol), acc_next (value the accumulator takes on en).
module rs_syn_cell
    import gf256_pkg::*;
#(
    parameter int ROOT_POW = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       first,
    input  logic [7:0] in_data,
    output logic [7:0] acc_next
);

    symbol_t acc;

    always_comb begin
        acc_next = in_data;
        if (!first) begin
            acc_next = gf_mul_alpha_pow(acc, ROOT_POW) ^ in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/rs_syndrome.sv
// Reed-Solomon syndrome calculator over GF(2^8), one symbol per clock.
// Ports: clk, rst (async, active high), in_valid/in_last/in_data (symbols,
//        highest degree first), syn_valid (pulse), syn_out (S_j at
//        [8j+7:8j]), syn_err (any S_j nonzero), len_err (optional).
// Build option: RSSYN_LEN_CHECK_EN adds a symbol counter, the CW_LEN
//        parameter and the len_err output.
module rs_syndrome
    import gf256_pkg::*;
#(
    parameter int NSYM   = 4,
    parameter int FCR    = 0
`ifdef RSSYN_LEN_CHECK_EN
    ,
    parameter int CW_LEN = 255
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [7:0]        in_data,
    output logic              syn_valid,
    output logic [NSYM*8-1:0] syn_out,
    output logic              syn_err
`ifdef RSSYN_LEN_CHECK_EN
    ,
    output logic              len_err
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t            state;
    logic              first;
    logic [NSYM*8-1:0] syn_next;

    assign first = (state == IDLE);

    for (genvar j = 0; j < NSYM; j++) begin : g_lane
        rs_syn_cell #(
            .ROOT_POW (FCR + j)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .en       (in_valid),
            .first    (first),
            .in_data  (in_data),
            .acc_next (syn_next[8*j +: 8])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            syn_valid <= 1'b0;
            syn_out   <= '0;
            syn_err   <= 1'b0;
        end else begin
            syn_valid <= in_valid && in_last;
            if (in_valid) begin
                if (in_last) begin
                    state   <= IDLE;
                    syn_out <= syn_next;
                    syn_err <= |syn_next;
                end else begin
                    state <= ACCUM;
                end
            end
        end
    end

`ifdef RSSYN_LEN_CHECK_EN
    localparam logic [7:0] CW_LEN_B = 8'(CW_LEN);

    logic [7:0] cnt;
    logic [7:0] cnt_next;

    // Count includes the current beat; saturates so long frames stay flagged.
    always_comb begin
        cnt_next = 8'd1;
        if (!first) begin
            cnt_next = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            len_err <= 1'b0;
        end else if (in_valid) begin
            if (in_last) begin
                cnt     <= '0;
                len_err <= (cnt_next != CW_LEN_B);
            end else begin
                cnt <= cnt_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rs_syndrome.sv
// Scoreboard bench for rs_syndrome (NSYM=4, FCR=0).
// Stimulus pushes expected syndromes; a monitor pops on syn_valid.
module tb_rs_syndrome;

    localparam int NSYM = 4;
`ifdef RSSYN_LEN_CHECK_EN
    localparam int CWL = 7;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_last;
    logic [7:0]  in_data;
    logic        syn_valid;
    logic [31:0] syn_out;
    logic        syn_err;
`ifdef RSSYN_LEN_CHECK_EN
    logic        len_err;
`endif

    always #5 clk = ~clk;

    rs_syndrome #(
        .NSYM   (NSYM),
        .FCR    (0)
`ifdef RSSYN_LEN_CHECK_EN
        ,
        .CW_LEN (CWL)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .syn_valid (syn_valid),
        .syn_out   (syn_out),
        .syn_err   (syn_err)
`ifdef RSSYN_LEN_CHECK_EN
        ,
        .len_err   (len_err)
`endif
    );

    typedef struct {
        logic [31:0] syn;
        logic        err;
        logic        len;
        int          cyc;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    logic [7:0] sbuf[0:299];
    logic [7:0] g[0:4];
    logic [7:0] m[0:5];
    logic [7:0] cw[0:9];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && syn_valid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_syn_valid syn_out=%h", syn_out);
            end else begin
                e = q.pop_front();
                chk("syn_out", syn_out, e.syn);
                chk("syn_err", {31'd0, syn_err}, {31'd0, e.err});
                chk("latency", cyc, e.cyc);
`ifdef RSSYN_LEN_CHECK_EN
                chk("len_err", {31'd0, len_err}, {31'd0, e.len});
`endif
            end
        end
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic len_exp(input int n);
`ifdef RSSYN_LEN_CHECK_EN
        return ((n > 255 ? 255 : n) != CWL);
`else
        return (n < 0);
`endif
    endfunction

    task automatic beat(input logic [7:0] d, input logic last,
                        input logic [31:0] es, input logic ee,
                        input logic el);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        if (last) q.push_back('{es, ee, el, cyc + 1});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_data  = 8'h00;
        end
    endtask

    task automatic send_buf(input int n, input bit gaps,
                            input logic [31:0] es, input logic ee);
        for (int i = 0; i < n; i++) begin
            beat(sbuf[i], (i == n - 1), es, ee, len_exp(n));
            if (gaps && i != n - 1 && $urandom_range(0, 2) == 0)
                idle($urandom_range(1, 3));
        end
    endtask

    initial begin
        logic [7:0] r;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_syn_valid", {31'd0, syn_valid}, 32'd0);
        chk("rst_syn_out", syn_out, 32'd0);
        chk("rst_syn_err", {31'd0, syn_err}, 32'd0);
`ifdef RSSYN_LEN_CHECK_EN
        chk("rst_len_err", {31'd0, len_err}, 32'd0);
`endif
        rst = 1'b0;
        idle(2);

        // All-zero 255-symbol codeword
        for (int i = 0; i < 255; i++) sbuf[i] = 8'h00;
        send_buf(255, 1'b0, 32'h0, 1'b0);
        idle(2);

        // 0x01, 0x00 -> alpha^j
        sbuf[0] = 8'h01;
        sbuf[1] = 8'h00;
        send_buf(2, 1'b0, 32'h08040201, 1'b1);

        // Back-to-back single-symbol codewords
        beat(8'h12, 1'b1, 32'h12121212, 1'b1, len_exp(1));
        beat(8'h34, 1'b1, 32'h34343434, 1'b1, len_exp(1));
        idle(2);

        // Golden codeword: message times g(x) = prod (x + alpha^j)
        g[0] = 8'h01;
        for (int k = 1; k < 5; k++) g[k] = 8'h00;
        r = 8'h01;
        for (int j = 0; j < 4; j++) begin
            for (int k = 4; k >= 0; k--)
                g[k] = (k > 0 ? g[k-1] : 8'h00) ^ gf_mul(g[k], r);
            r = gf_mul(r, 8'h02);
        end
        m[0] = 8'h5A; m[1] = 8'h01; m[2] = 8'hC3;
        m[3] = 8'h77; m[4] = 8'h10; m[5] = 8'hFE;
        for (int i = 0; i < 10; i++) cw[i] = 8'h00;
        for (int i = 0; i < 6; i++)
            for (int k = 0; k < 5; k++)
                cw[i+k] = cw[i+k] ^ gf_mul(m[i], g[k]);
        for (int t = 0; t < 10; t++) sbuf[t] = cw[9-t];
        send_buf(10, 1'b1, 32'h0, 1'b0);
        idle(1);

        // Error 0xA5 at degree 1
        sbuf[8] = sbuf[8] ^ 8'hA5;
        send_buf(10, 1'b1, 32'h41AE57A5, 1'b1);
        idle(2);

        // Reset mid-codeword, then the two-beat case again
        beat(8'h11, 1'b0, 32'h0, 1'b0, 1'b0);
        beat(8'h22, 1'b0, 32'h0, 1'b0, 1'b0);
        beat(8'h33, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_syn_out", syn_out, 32'd0);
        sbuf[0] = 8'h01;
        sbuf[1] = 8'h00;
        send_buf(2, 1'b0, 32'h08040201, 1'b1);
        idle(2);

        // 7- and 6-symbol zero codewords (length check lengths)
        for (int i = 0; i < 7; i++) sbuf[i] = 8'h00;
        send_buf(7, 1'b0, 32'h0, 1'b0);
        send_buf(6, 1'b0, 32'h0, 1'b0);
        idle(3);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        while (q.size() != 0) begin
            e = q.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_syn_valid required_syn=%h", e.syn);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
